// File: rtl/riscv_ooo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_ooo_pkg
//  Brief    : Shared out-of-order core definitions (widths, FU ids, CDB packet)
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_ooo_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int TAG_WIDTH  = 3;
    localparam int REG_ADDR_W = 5;

    // Functional-unit slot numbers on the CDB arbiter request vector
    localparam int FU_ALU = 0;
    localparam int FU_FPU = 1;
    localparam int FU_LSU = 2;
    localparam int FU_BRU = 3;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] result;
        logic [TAG_WIDTH-1:0]  tag;
        logic [REG_ADDR_W-1:0] dest;
    } cdb_pkt_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Rotating-priority picker. Finds the first set request at or
//             after ptr (wrapping) using a doubled request vector.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    localparam logic [2*N-1:0] c_one = {{(2*N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_masked;

    // Upper copy covers the wrap-around; lower copy is masked below ptr.
    assign w_dbl    = {req, req};
    assign w_masked = w_dbl & ~((c_one << ptr) - c_one);

    // Lowest surviving bit wins; scanning downward lets the lowest overwrite.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (w_masked[i]) begin
                any        = 1'b1;
                idx        = PW'(i % N);
                gnt        = '0;
                gnt[i % N] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_rr_arbiter
//  Brief    : Round-robin arbiter for the shared Common Data Bus. One
//             same-cycle ack per cycle; registered broadcast to snoopers.
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_rr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = riscv_ooo_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH  = riscv_ooo_pkg::TAG_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [N_REQ-1:0]                          req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]               req_result,
    input  logic [N_REQ*TAG_WIDTH-1:0]                req_tag,
    input  logic [N_REQ*riscv_ooo_pkg::REG_ADDR_W-1:0] req_dest,
    output logic [N_REQ-1:0]                          req_ack,
    input  logic                                      cdb_stall,
    input  logic                                      flush,
    output logic                                      cdb_valid,
    output logic [DATA_WIDTH-1:0]                     cdb_result,
    output logic [TAG_WIDTH-1:0]                      cdb_tag,
    output logic [riscv_ooo_pkg::REG_ADDR_W-1:0]      cdb_dest,
    output logic [N_REQ*16-1:0]                       grant_cnt
);

    import riscv_ooo_pkg::*;

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic                  w_eligible;
    logic [N_REQ-1:0]      w_req_elig;
    logic [N_REQ-1:0]      w_gnt;
    logic [PW-1:0]         w_idx;
    logic                  w_any;

    logic [DATA_WIDTH-1:0] w_sel_result;
    logic [TAG_WIDTH-1:0]  w_sel_tag;
    logic [REG_ADDR_W-1:0] w_sel_dest;

    logic [PW-1:0]         r_ptr;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [REG_ADDR_W-1:0] r_dest;
    logic [15:0]           r_cnt [N_REQ];

    // Grants only when neither a squash nor downstream back-pressure is active.
    assign w_eligible = ~flush & ~cdb_stall;
    assign w_req_elig = req_valid & {N_REQ{w_eligible}};

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req (w_req_elig),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx),
        .any (w_any)
    );

    assign req_ack = w_gnt;

    // Select the winner's payload; only the one-hot grant steers this mux.
    always_comb begin
        w_sel_result = '0;
        w_sel_tag    = '0;
        w_sel_dest   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_result = req_result[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_tag    = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                w_sel_dest   = req_dest[i*REG_ADDR_W +: REG_ADDR_W];
            end
        end
    end

    // Priority pointer moves just past the winner; holds through stall/flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    // Broadcast register: valid follows the grant, payload holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_tag    <= '0;
            r_dest   <= '0;
        end else begin
            r_valid <= w_any;
            if (w_any) begin
                r_result <= w_sel_result;
                r_tag    <= w_sel_tag;
                r_dest   <= w_sel_dest;
            end
        end
    end

    // A flush kills the broadcast currently on the bus, not just future ones.
    assign cdb_valid  = r_valid & ~flush;
    assign cdb_result = r_result;
    assign cdb_tag    = r_tag;
    assign cdb_dest   = r_dest;

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
            // Saturating per-FU grant counter, cleared only by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt[g] <= '0;
                end else if (w_gnt[g] && (r_cnt[g] != 16'hFFFF)) begin
                    r_cnt[g] <= r_cnt[g] + 16'd1;
                end
            end
            assign grant_cnt[g*16 +: 16] = r_cnt[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_rr_arbiter
//  Brief    : Self-checking bench for cdb_rr_arbiter (N_REQ=4): directed
//             scenarios plus randomized traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 3;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_result;
    logic [N*TW-1:0] req_tag;
    logic [N*RW-1:0] req_dest;
    logic [N-1:0]    req_ack;
    logic            cdb_stall;
    logic            flush;
    logic            cdb_valid;
    logic [DW-1:0]   cdb_result;
    logic [TW-1:0]   cdb_tag;
    logic [RW-1:0]   cdb_dest;
    logic [N*16-1:0] grant_cnt;

    int n_checks = 0;
    int n_errors = 0;

    cdb_rr_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_result (req_result),
        .req_tag    (req_tag),
        .req_dest   (req_dest),
        .req_ack    (req_ack),
        .cdb_stall  (cdb_stall),
        .flush      (flush),
        .cdb_valid  (cdb_valid),
        .cdb_result (cdb_result),
        .cdb_tag    (cdb_tag),
        .cdb_dest   (cdb_dest),
        .grant_cnt  (grant_cnt)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic [DW-1:0] r, input logic [TW-1:0] t,
                          input logic [RW-1:0] d);
        req_result[i*DW +: DW] = r;
        req_tag[i*TW +: TW]    = t;
        req_dest[i*RW +: RW]   = d;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        cdb_stall = 1'b0;
        flush     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        req_result = '0;
        req_tag    = '0;
        req_dest   = '0;
        cdb_stall  = 1'b0;
        flush      = 1'b0;
        repeat (2) tick();
        #4;
        n_checks++;
        if (req_ack !== 4'b0000) begin
            n_errors++; $display("FAIL reset_ack: got %b expected 0000", req_ack);
        end
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b expected 0", cdb_valid);
        end
        n_checks++;
        if (cdb_result !== 32'h0 || cdb_tag !== 3'd0 || cdb_dest !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_data: got %h/%0d/%0d expected 0/0/0", cdb_result, cdb_tag, cdb_dest);
        end
        n_checks++;
        if (grant_cnt !== 64'h0) begin
            n_errors++; $display("FAIL reset_cnt: got %h expected 0", grant_cnt);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        set_fu(2, 32'hDEAD_BEEF, 3'd3, 5'd7);
        req_valid = 4'b0100;
        #4;
        n_checks++;
        if (req_ack !== 4'b0100) begin
            n_errors++; $display("FAIL single_ack: got %b expected 0100", req_ack);
        end
        tick();
        req_valid = 4'b0000;
        #4;
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_result !== 32'hDEAD_BEEF || cdb_tag !== 3'd3 || cdb_dest !== 5'd7) begin
            n_errors++;
            $display("FAIL single_bcast: got v=%b %h/%0d/%0d expected v=1 deadbeef/3/7",
                     cdb_valid, cdb_result, cdb_tag, cdb_dest);
        end
        n_checks++;
        if (grant_cnt !== 64'h0000_0001_0000_0000) begin
            n_errors++; $display("FAIL single_cnt: got %h expected 0000000100000000", grant_cnt);
        end
        tick();
    endtask

    // Pointer is 3 here after the single-requester grant to FU2.
    task automatic test_wrap();
        set_fu(3, 32'h3333_0003, 3'd5, 5'd30);
        set_fu(0, 32'h0000_1111, 3'd1, 5'd1);
        req_valid = 4'b1001;
        #4;
        n_checks++;
        if (req_ack !== 4'b1000) begin
            n_errors++; $display("FAIL wrap_ack_fu3: got %b expected 1000", req_ack);
        end
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_errors++; $display("FAIL wrap_idle_valid: got %b expected 0", cdb_valid);
        end
        tick();
        set_fu(3, 32'h3333_0004, 3'd6, 5'd31);
        #4;
        n_checks++;
        if (req_ack !== 4'b0001) begin
            n_errors++; $display("FAIL wrap_ack_fu0: got %b expected 0001", req_ack);
        end
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_result !== 32'h3333_0003 || cdb_tag !== 3'd5 || cdb_dest !== 5'd30) begin
            n_errors++;
            $display("FAIL wrap_bcast_fu3: got v=%b %h/%0d/%0d expected v=1 33330003/5/30",
                     cdb_valid, cdb_result, cdb_tag, cdb_dest);
        end
        tick();
        req_valid = 4'b0000;
        #4;
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_result !== 32'h0000_1111 || cdb_tag !== 3'd1 || cdb_dest !== 5'd1) begin
            n_errors++;
            $display("FAIL wrap_bcast_fu0: got v=%b %h/%0d/%0d expected v=1 00001111/1/1",
                     cdb_valid, cdb_result, cdb_tag, cdb_dest);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < N; i++) set_fu(i, 32'h7700_0000 + 32'(i), TW'(i), RW'(i));
        req_valid = 4'b1111;
        tick();
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", cdb_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (cdb_valid !== 1'b0 || cdb_result !== 32'h0) begin
            n_errors++;
            $display("FAIL rstmid_async: got v=%b r=%h expected v=0 r=0", cdb_valid, cdb_result);
        end
        n_checks++;
        if (grant_cnt !== 64'h0) begin
            n_errors++; $display("FAIL rstmid_cnt: got %h expected 0", grant_cnt);
        end
        tick();
        rst_n = 1'b1;
        #4;
        n_checks++;
        if (req_ack !== 4'b0001) begin
            n_errors++; $display("FAIL rstmid_ptr0: got %b expected 0001", req_ack);
        end
        tick();
        req_valid = 4'b0000;
        #4;
        n_checks++;
        if (grant_cnt !== 64'h0000_0000_0000_0001) begin
            n_errors++; $display("FAIL rstmid_cnt_after: got %h expected 0000000000000001", grant_cnt);
        end
        tick();
    endtask

    task automatic test_all_four();
        logic [3:0]    exp_ack;
        logic [DW-1:0] exp_res;
        int            w;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++)
                set_fu(i, 32'h00A0_0000 | 32'(k << 8) | 32'(i), TW'(i), RW'(8 + i));
            req_valid = 4'b1111;
            #4;
            exp_ack = 4'b0001 << (k % 4);
            n_checks++;
            if (req_ack !== exp_ack) begin
                n_errors++; $display("FAIL all4_ack[%0d]: got %b expected %b", k, req_ack, exp_ack);
            end
            if (k == 0) begin
                n_checks++;
                if (cdb_valid !== 1'b0) begin
                    n_errors++; $display("FAIL all4_valid[0]: got %b expected 0", cdb_valid);
                end
            end else begin
                w       = (k - 1) % 4;
                exp_res = 32'h00A0_0000 | 32'((k - 1) << 8) | 32'(w);
                n_checks++;
                if (cdb_valid !== 1'b1 || cdb_result !== exp_res || cdb_tag !== TW'(w) || cdb_dest !== RW'(8 + w)) begin
                    n_errors++;
                    $display("FAIL all4_bcast[%0d]: got v=%b %h/%0d/%0d expected v=1 %h/%0d/%0d",
                             k, cdb_valid, cdb_result, cdb_tag, cdb_dest, exp_res, w, 8 + w);
                end
            end
            tick();
        end
    endtask

    // Continues from the all-four burst: pointer back at 0.
    task automatic test_stall();
        set_fu(0, 32'h5500_0000, 3'd2, 5'd20);
        set_fu(1, 32'h5511_1111, 3'd6, 5'd21);
        req_valid = 4'b0011;
        cdb_stall = 1'b1;
        #4;
        n_checks++;
        if (req_ack !== 4'b0000) begin
            n_errors++; $display("FAIL stall_ack0: got %b expected 0000", req_ack);
        end
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_result !== 32'h00A0_0703) begin
            n_errors++;
            $display("FAIL stall_inflight: got v=%b r=%h expected v=1 r=00a00703", cdb_valid, cdb_result);
        end
        n_checks++;
        if (grant_cnt !== 64'h0002_0002_0002_0002) begin
            n_errors++; $display("FAIL all4_cnt: got %h expected 0002000200020002", grant_cnt);
        end
        for (int c = 1; c < 3; c++) begin
            tick();
            #4;
            n_checks++;
            if (req_ack !== 4'b0000 || cdb_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_drained[%0d]: got ack=%b v=%b expected ack=0000 v=0", c, req_ack, cdb_valid);
            end
        end
        tick();
        cdb_stall = 1'b0;
        #4;
        n_checks++;
        if (req_ack !== 4'b0001) begin
            n_errors++; $display("FAIL stall_release_ack: got %b expected 0001", req_ack);
        end
        tick();
    endtask

    // FU0 was granted in the previous cycle; its broadcast is now on the bus.
    task automatic test_flush();
        req_valid = 4'b0010;
        flush     = 1'b1;
        #4;
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_squash: got %b expected 0", cdb_valid);
        end
        n_checks++;
        if (req_ack !== 4'b0000) begin
            n_errors++; $display("FAIL flush_ack: got %b expected 0000", req_ack);
        end
        tick();
        flush = 1'b0;
        #4;
        n_checks++;
        if (req_ack !== 4'b0010 || cdb_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_resume: got ack=%b v=%b expected ack=0010 v=0", req_ack, cdb_valid);
        end
        tick();
        req_valid = 4'b0000;
        #4;
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_result !== 32'h5511_1111 || cdb_tag !== 3'd6 || cdb_dest !== 5'd21) begin
            n_errors++;
            $display("FAIL flush_next_bcast: got v=%b %h/%0d/%0d expected v=1 55111111/6/21",
                     cdb_valid, cdb_result, cdb_tag, cdb_dest);
        end
        tick();
    endtask

    // Random FU traffic that honours hold-until-ack, checked against a model
    // that searches from its own pointer and tracks per-FU waiting time.
    task automatic test_random();
        logic [N-1:0]    pend;
        int              m_ptr;
        logic            m_valid;
        logic [DW-1:0]   m_result;
        logic [TW-1:0]   m_tag;
        logic [RW-1:0]   m_dest;
        int              m_cnt [N];
        int              wait_cnt [N];
        int              win;
        int              idx;
        int              max_wait;
        logic [N-1:0]    exp_ack;
        logic [N*16-1:0] exp_cnt;
        logic [DW-1:0]   s_result;
        logic [TW-1:0]   s_tag;
        logic [RW-1:0]   s_dest;
        apply_reset();
        pend = '0; m_ptr = 0; m_valid = 1'b0; m_result = '0; m_tag = '0; m_dest = '0;
        s_result = '0; s_tag = '0; s_dest = '0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; wait_cnt[i] = 0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 2 == 0)) begin
                    pend[i] = 1'b1;
                    set_fu(i, $urandom, TW'($urandom), RW'($urandom));
                end
            end
            cdb_stall = ($urandom % 5 == 0);
            flush     = ($urandom % 10 == 0);
            req_valid = pend;
            #4;
            win = -1;
            if (!flush && !cdb_stall) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (win < 0 && pend[idx]) win = idx;
                end
            end
            exp_ack = (win >= 0) ? (4'b0001 << win) : 4'b0000;
            for (int i = 0; i < N; i++) exp_cnt[i*16 +: 16] = 16'(m_cnt[i]);
            n_checks++;
            if (req_ack !== exp_ack) begin
                n_errors++; $display("FAIL rand_ack @%0d: got %b expected %b", cyc, req_ack, exp_ack);
            end
            n_checks++;
            if (cdb_valid !== (m_valid && !flush)) begin
                n_errors++;
                $display("FAIL rand_valid @%0d: got %b expected %b", cyc, cdb_valid, m_valid && !flush);
            end
            n_checks++;
            if (cdb_result !== m_result || cdb_tag !== m_tag || cdb_dest !== m_dest) begin
                n_errors++;
                $display("FAIL rand_data @%0d: got %h/%0d/%0d expected %h/%0d/%0d",
                         cyc, cdb_result, cdb_tag, cdb_dest, m_result, m_tag, m_dest);
            end
            n_checks++;
            if (grant_cnt !== exp_cnt) begin
                n_errors++; $display("FAIL rand_cnt @%0d: got %h expected %h", cyc, grant_cnt, exp_cnt);
            end
            if (!flush && !cdb_stall) begin
                for (int i = 0; i < N; i++)
                    if (pend[i] && i != win) wait_cnt[i]++;
            end
            max_wait = 0;
            for (int i = 0; i < N; i++) if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            n_checks++;
            if (max_wait >= N) begin
                n_errors++; $display("FAIL rand_fair @%0d: got wait %0d expected < %0d", cyc, max_wait, N);
            end
            if (win >= 0) begin
                s_result = req_result[win*DW +: DW];
                s_tag    = req_tag[win*TW +: TW];
                s_dest   = req_dest[win*RW +: RW];
            end
            tick();
            if (win >= 0) begin
                m_ptr    = (win + 1) % N;
                m_valid  = 1'b1;
                m_result = s_result;
                m_tag    = s_tag;
                m_dest   = s_dest;
                if (m_cnt[win] < 16'hFFFF) m_cnt[win]++;
                pend[win]     = 1'b0;
                wait_cnt[win] = 0;
            end else begin
                m_valid = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom % 2 == 0) begin
                        pend[i] = 1'b0; wait_cnt[i] = 0;
                    end
                end
            end
        end
        req_valid = '0; cdb_stall = 1'b0; flush = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        apply_reset();
        req_valid = 4'b0010;
        repeat (70000) tick();
        req_valid = 4'b0000;
        #4;
        n_checks++;
        if (grant_cnt !== 64'h0000_0000_FFFF_0000) begin
            n_errors++; $display("FAIL sat_cnt: got %h expected 00000000ffff0000", grant_cnt);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_reset_mid();
        test_all_four();
        test_stall();
        test_flush();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
